// File: rtl/kaktovik_pkg.sv
// Shared constants, types and the Kaktovik segment pattern for the scan driver.
// Segment bits are ordered {h,g,f,e,d,c,b,a}.
package kaktovik_pkg;

  localparam int unsigned BASE  = 20;
  localparam int unsigned SEG_W = 8;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;
  localparam int unsigned SEG_H = 7;

  typedef logic [4:0] digit_t;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  // Units (d % 5) fill the e..a field; fives (d / 5) fill the h..f field.
  function automatic logic [SEG_W-1:0] kaktovik_pattern(input digit_t digit, input logic blank);
    logic [SEG_W-1:0] p;
    logic [2:0]       u;
    logic [2:0]       f;
    p = '0;
    u = 3'(digit % 5'd5);
    f = 3'(digit / 5'd5);
    if (blank) begin
      p = '0;
    end else if (digit == '0) begin
      p[SEG_C] = 1'b1;
    end else begin
      case (u)
        3'd1:    p[SEG_A]       = 1'b1;
        3'd2:    p[SEG_C:SEG_A] = '1;
        3'd3:    p[SEG_D:SEG_A] = '1;
        3'd4:    p[SEG_E:SEG_A] = '1;
        default: p[SEG_B]       = 1'b0;
      endcase
      case (f)
        3'd1:    p[SEG_F]       = 1'b1;
        3'd2:    p[SEG_G:SEG_F] = '1;
        3'd3:    p[SEG_H:SEG_F] = '1;
        default: p[SEG_H]       = 1'b0;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/kaktovik_scan_driver_if.sv
// Load handshake between the numeric datapath (master) and the scan driver (slave).
interface kaktovik_scan_driver_if #(
  parameter int unsigned WIDTH = 18
);
  logic             load;
  logic [WIDTH-1:0] value;
  logic             ready;
  logic             done;
  logic             ovf;

  modport master (output load, output value, input ready, input done, input ovf);
  modport slave  (input load, input value, output ready, output done, output ovf);
endinterface

// File: rtl/kaktovik_div20_step.sv
// One base-20 long-division step: splits an accumulator into quotient and digit.
module kaktovik_div20_step
  import kaktovik_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] quot_o,
  output digit_t           rem_o
);

  assign quot_o = acc_i / WIDTH'(BASE);
  assign rem_o  = digit_t'(acc_i % WIDTH'(BASE));

endmodule

// File: rtl/kaktovik_scan_driver.sv
// Time-multiplexed Kaktovik display driver: serial base-20 conversion, atomic commit
// into a display store, ripple leading-zero blanking and a prescaled digit scanner.
module kaktovik_scan_driver
  import kaktovik_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  kaktovik_scan_driver_if.slave   bus,
  input  logic                    rbz,
  input  logic                    lt_n,
  input  logic                    bi_n,
  input  logic                    al,
  output logic [SEG_W-1:0]        seg,
  output logic [DIGITS-1:0]       dig
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]         acc_q, acc_d, quot;
  digit_t                   rem;
  digit_t [DIGITS-1:0]      conv_q, conv_d;
  digit_t [DIGITS-1:0]      store_q, store_d;
  logic [DIGITS-1:0]        blank_q, blank_d, blank_new;
  logic                     ovf_q, ovf_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [PRE_W-1:0]         pre_q, pre_d;
  logic [SEG_W-1:0]         raw_q, raw_d, cur_pat;
  logic [DIGITS-1:0]        dig_q, dig_d;
  logic                     tick;
  logic                     above_zero;

  kaktovik_div20_step #(
    .WIDTH (WIDTH)
  ) u_div20 (
    .acc_i  (acc_q),
    .quot_o (quot),
    .rem_o  (rem)
  );

  // FSM: state register, next-state logic, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.load) state_d = StConv;
      StConv:   if (cnt_q == CNT_W'(DIGITS - 1)) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.done  = (state_q == StCommit);
    bus.ovf   = ovf_q;
  end

  // A digit blanks only when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    above_zero = 1'b1;
    blank_new  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero   = above_zero & (conv_q[i] == '0);
      blank_new[i] = rbz & above_zero & (i != 0);
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    store_d = store_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          acc_d = bus.value;
          cnt_d = '0;
        end
      end
      StConv: begin
        acc_d = quot;
        cnt_d = cnt_q + 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) conv_d[i] = rem;
        end
      end
      StCommit: begin
        store_d = conv_q;
        blank_d = blank_new;
        ovf_d   = (acc_q != '0);
      end
      default: ;
    endcase
  end

  // Scanner reads the registered store, so a commit on a tick edge shows next tick.
  always_comb begin
    tick    = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d   = tick ? '0 : pre_q + 1'b1;
    cur_pat = ovf_q ? kaktovik_pattern(digit_t'(BASE - 1), 1'b0)
                    : kaktovik_pattern(store_q[idx_q], blank_q[idx_q]);
    idx_d   = idx_q;
    raw_d   = raw_q;
    dig_d   = dig_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      raw_d = (cur_pat | {SEG_W{~lt_n}}) & {SEG_W{bi_n}};
      dig_d = DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      conv_q  <= '0;
      store_q <= '0;
      blank_q <= '1;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      pre_q   <= '0;
      raw_q   <= '0;
      dig_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      conv_q  <= conv_d;
      store_q <= store_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      raw_q   <= raw_d;
      dig_q   <= dig_d;
    end
  end

  assign seg = raw_q ^ {SEG_W{~al}};
  assign dig = dig_q;

endmodule

// File: doc/kaktovik_scan_driver.md
Name: kaktovik_scan_driver

Overview:
- Multi-digit, time-multiplexed Kaktovik numeral display driver.
- Accepts an unsigned binary value through a ready/valid-style load and converts it sequentially to DIGITS base-20 digits, one digit per clock.
- Applies ripple leading-zero blanking and drives one shared 8-segment bus (a..h) plus one-hot digit enables, scanning digits at a programmable rate.
- Sits between the numeric datapath and a physical multiplexed Kaktovik display.

Parameters:
- DIGITS, 4, number of base-20 digit positions (>=1).
- WIDTH, 18, width of the binary input value.
- SCAN_DIV, 1000, clocks per digit dwell (>=1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  request to convert value; accepted only when ready=1.
- value  in  WIDTH  unsigned binary value to display.
- ready  out  1  high in IDLE; low while converting.
- done  out  1  one-cycle pulse when a new conversion commits to the display.
- ovf  out  1  sticky-until-next-commit: last committed value >= 20**DIGITS.
- rbz  in  1  leading-zero blanking enable.
- lt_n  in  1  lamp test, active-low; lights all segments of the scanned digit.
- bi_n  in  1  blanking, active-low; forces all segments off; overrides lt_n.
- al  in  1  segment active level: 1 = active-high seg, 0 = inverted seg.
- seg  out  8  segments {h,g,f,e,d,c,b,a}.
- dig  out  DIGITS  one-hot digit enable, active-high; bit 0 = least significant digit.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; ready=1, done=0, ovf=0.
  - Display digit store and blank mask cleared to all-blank.
  - Scan index 0, prescaler 0.
  - Internal raw segment register 0; dig=0.
- Reset mid-conversion: conversion is discarded; nothing is committed.
- FSM, IDLE:
  - On load & ready, latch value into accumulator and go to CONV with count 0. ready drops the next cycle.
- FSM, CONV:
  - Each cycle: digit[count] = acc % 20, acc = acc / 20, count++.
  - After DIGITS cycles, go to COMMIT.
- FSM, COMMIT (one cycle):
  - Copy all digits, blank mask and ovf into the display store atomically.
  - ovf = (residual acc != 0).
  - Pulse done; return to IDLE; ready=1 on the following cycle.
- Latency: load accepted at edge t -> done high in cycle t+DIGITS+1 -> new data visible from the next scan tick.
- load while ready=0 is ignored (no queueing).
- Overflow: when ovf=1, every digit displays the pattern for 19 and the blank mask is ignored.
- Blank mask: digit i is blanked iff rbz=1, digit i==0, and all digits above i are 0. Digit 0 is never blanked, so value 0 shows a single zero.
- Digit pattern for d in 0..19, with u=d%5 and f=d/5:
  - bits e..a: u=0 -> 00000; u=1 -> 00001; u=2 -> 00111; u=3 -> 01111; u=4 -> 11111.
  - bits h,g,f: f=0 -> 000; f=1 -> 001; f=2 -> 011; f=3 -> 111.
  - Exception: d=0 unblanked -> 00000100 (segment c only).
  - Blanked digit -> 00000000.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On wrap (scan tick), the scan index advances and wraps DIGITS-1 -> 0.
  - On each tick, raw register = ((pattern(store[idx]) & ~blanked) | {8{~lt_n}}) & {8{bi_n}}, and dig = onehot(idx).
  - SCAN_DIV=1: advance every cycle.
  - First tick after reset drives index 0. dig and raw update on the same edge, so there is no ghosting.
- Output polarity: seg = raw ^ {8{~al}}, combinational on a static strap.
- lt_n and bi_n are sampled at the scan tick only.
- Commit coinciding with a scan tick: the tick uses the pre-commit store. The scan index is never disturbed by commits.

Decomposition:
- Package kaktovik_pkg:
  - Constants BASE=20 and SEG_W=8.
  - Segment-index constants a..h.
  - Function kaktovik_pattern(digit, blank) returning 8 bits.
  - Digit typedef logic [4:0].
- One sub-module, kaktovik_div20_step: combinational acc -> {acc/20, acc%20}, instantiated once in CONV.

Test Plan:
- DIGITS=4, SCAN_DIV=1, rbz=1, load value=0 -> done at t+5. Scan shows dig=0001 seg=00000100; dig=0010/0100/1000 seg=00000000.
- value=8421 (digits 1,1,1,1), al=1 -> every dig shows seg=00000001; ovf=0.
- value=399 (digits 0,0,19,19), rbz=1 -> digits 3,2 seg=00000000; digits 1,0 seg=11111111. With rbz=0 -> digits 3,2 seg=00000100.
- value=200000 (>=160000) -> ovf=1; all digits seg=11111111. Then load 5 -> ovf=0; digit 0 seg=00100000.
- al=0, lt_n=0 -> seg=00000000 on every digit. Then bi_n=0, lt_n=0 -> seg=11111111.
- Second load during CONV ignored (ready=0). rst_n pulse mid-CONV -> no done, dig=0, ready=1.
